mdu_hilo_ctrl: RTL and testbench

- Issue/commit controller between the EX stage and the multi-cycle multiply/divide unit; owns the architectural HI/LO registers.
- Accepts MDU ops from EX and stalls the pipeline while the unit runs. Holds the operands and HI/LO snapshot stable for the unit.
- On completion, commits the 64-bit result to HI/LO, or returns it to the GPR path for MUL.
- Handles MTHI/MTLO writes and pipeline flush.

---
 rtl/mdu_hilo_ctrl_pkg.sv | 24 ++
 rtl/mdu_hilo_ctrl_hilo_reg.sv | 31 +++
 rtl/mdu_hilo_ctrl.sv | 148 ++++++++++++++
 tb/tb_mdu_hilo_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/mdu_hilo_ctrl_pkg.sv
// rtl/mdu_hilo_ctrl_pkg.sv - shared opcode, data and state types for the MDU issue/commit path
package mdu_hilo_ctrl_pkg;

  typedef enum logic [3:0] {
    OP_NOP, OP_MUL, OP_MULT, OP_MULTU, OP_MADD, OP_MADDU,
    OP_MSUB, OP_MSUBU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO
  } Oper_t;

  typedef logic [63:0] DoubleWord_t;

  typedef logic [1:0] MdState_t;
  localparam MdState_t IDLE = 2'd0;
  localparam MdState_t RUN  = 2'd1;
  localparam MdState_t DONE = 2'd2;

  function automatic logic is_long_op(input Oper_t op);
    return op inside {OP_MUL, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU, OP_DIV, OP_DIVU};
  endfunction

  function automatic logic is_short_op(input Oper_t op);
    return op inside {OP_MULT, OP_MULTU};
  endfunction

endpackage

// File: rtl/mdu_hilo_ctrl_hilo_reg.sv
// rtl/mdu_hilo_ctrl_hilo_reg.sv - architectural HI/LO storage with split and full write enables
module mdu_hilo_ctrl_hilo_reg
  import mdu_hilo_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        wr_hi,
  input  logic        wr_lo,
  input  logic        wr_all,
  input  logic [63:0] wdata,
  output logic [63:0] hilo
);

  logic [31:0] hi;
  logic [31:0] lo;

  // A flushed instruction never reaches architectural state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi <= 32'd0;
      lo <= 32'd0;
    end else if (!flush) begin
      if (wr_all || wr_hi) hi <= wdata[63:32];
      if (wr_all || wr_lo) lo <= wdata[31:0];
    end
  end

  assign hilo = {hi, lo};

endmodule

// File: rtl/mdu_hilo_ctrl.sv
// rtl/mdu_hilo_ctrl.sv - issue/commit controller between EX and the multi-cycle multiply/divide unit
module mdu_hilo_ctrl
  import mdu_hilo_ctrl_pkg::*;
#(
  parameter int MAX_CYC = 40,
  parameter int CNT_W   = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        req_valid,
  input  Oper_t       req_op,
  input  logic [31:0] req_reg1,
  input  logic [31:0] req_reg2,
  output logic        stall_req,
  output logic [31:0] mul_result,
  output logic        mul_valid,
  output logic [63:0] hilo,
  output Oper_t       mdu_op,
  output logic [31:0] mdu_reg1,
  output logic [31:0] mdu_reg2,
  output logic [63:0] mdu_hilo,
  output logic        mdu_flush,
  input  logic [63:0] mdu_ret,
  input  logic        mdu_busy,
  output logic        timeout
);

  MdState_t    state;
  Oper_t       op_q;
  logic [31:0] reg1_q;
  logic [31:0] reg2_q;
  DoubleWord_t snap_q;
  DoubleWord_t result_q;
  logic [CNT_W-1:0] cnt;
  logic        abort_q;

  logic        wr_hi;
  logic        wr_lo;
  logic        wr_all;
  DoubleWord_t wr_data;

  logic req_long;
  assign req_long  = req_valid && is_long_op(req_op);
  assign mdu_flush = flush;

  always_comb begin
    mdu_op     = OP_NOP;
    mdu_reg1   = req_reg1;
    mdu_reg2   = req_reg2;
    mdu_hilo   = hilo;
    stall_req  = 1'b0;
    mul_valid  = 1'b0;
    mul_result = result_q[31:0];
    wr_hi      = 1'b0;
    wr_lo      = 1'b0;
    wr_all     = 1'b0;
    wr_data    = mdu_ret;
    case (state)
      IDLE: begin
        if (req_valid) mdu_op = req_op;
        if (req_long) begin
          stall_req = !flush;
        end else if (req_valid && is_short_op(req_op)) begin
          wr_all = 1'b1;
        end else if (req_valid && (req_op == OP_MTHI || req_op == OP_MTLO)) begin
          wr_data = {req_reg1, req_reg1};
          wr_hi   = (req_op == OP_MTHI);
          wr_lo   = (req_op == OP_MTLO);
        end
      end
      RUN: begin
        mdu_op    = op_q;
        mdu_reg1  = reg1_q;
        mdu_reg2  = reg2_q;
        mdu_hilo  = snap_q;
        stall_req = !flush;
      end
      DONE: begin
        // Unit sees NOP here so the still-presented instruction is not restarted.
        wr_data = result_q;
        if (op_q == OP_MUL) mul_valid = !flush && !abort_q;
        else                wr_all    = !abort_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      op_q     <= OP_NOP;
      reg1_q   <= 32'd0;
      reg2_q   <= 32'd0;
      snap_q   <= 64'd0;
      result_q <= 64'd0;
      cnt      <= '0;
      abort_q  <= 1'b0;
      timeout  <= 1'b0;
    end else if (flush) begin
      state   <= IDLE;
      cnt     <= '0;
      abort_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_long) begin
            state   <= RUN;
            op_q    <= req_op;
            reg1_q  <= req_reg1;
            reg2_q  <= req_reg2;
            snap_q  <= hilo;
            cnt     <= CNT_W'(1);
            abort_q <= 1'b0;
          end
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (!mdu_busy) begin
            result_q <= mdu_ret;
            state    <= DONE;
          end else if (cnt == CNT_W'(MAX_CYC)) begin
            timeout <= 1'b1;
            abort_q <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
          cnt   <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  mdu_hilo_ctrl_hilo_reg u_hilo_reg (
    .clk    (clk),
    .rst    (rst),
    .flush  (flush),
    .wr_hi  (wr_hi),
    .wr_lo  (wr_lo),
    .wr_all (wr_all),
    .wdata  (wr_data),
    .hilo   (hilo)
  );

endmodule

// File: tb/tb_mdu_hilo_ctrl.sv
// tb/tb_mdu_hilo_ctrl.sv - scoreboard bench for mdu_hilo_ctrl with a behavioural MDU model
module tb_mdu_hilo_ctrl;
  import mdu_hilo_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        req_valid = 1'b0;
  Oper_t       req_op = OP_NOP;
  logic [31:0] req_reg1 = '0;
  logic [31:0] req_reg2 = '0;
  logic        stall_req;
  logic [31:0] mul_result;
  logic        mul_valid;
  logic [63:0] hilo;
  Oper_t       mdu_op;
  logic [31:0] mdu_reg1;
  logic [31:0] mdu_reg2;
  logic [63:0] mdu_hilo;
  logic        mdu_flush;
  logic [63:0] mdu_ret;
  logic        mdu_busy;
  logic        timeout;

  int checks = 0;
  int failures = 0;
  logic        obs = 1'b0;
  logic        stuck = 1'b0;
  int          ucyc = 0;
  logic [63:0] hilo_q[$];
  logic [31:0] mul_q[$];

  mdu_hilo_ctrl #(.MAX_CYC(40), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .flush(flush), .req_valid(req_valid), .req_op(req_op),
    .req_reg1(req_reg1), .req_reg2(req_reg2), .stall_req(stall_req),
    .mul_result(mul_result), .mul_valid(mul_valid), .hilo(hilo), .mdu_op(mdu_op),
    .mdu_reg1(mdu_reg1), .mdu_reg2(mdu_reg2), .mdu_hilo(mdu_hilo),
    .mdu_flush(mdu_flush), .mdu_ret(mdu_ret), .mdu_busy(mdu_busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Behavioural unit: short ops answer at once, long ops need 35 cycles in RUN.
  always_ff @(posedge clk) ucyc <= is_long_op(mdu_op) ? ucyc + 1 : 0;

  always_comb begin
    longint sp;
    logic [63:0] up;
    int q, r;
    sp = longint'($signed(mdu_reg1)) * longint'($signed(mdu_reg2));
    up = {32'd0, mdu_reg1} * {32'd0, mdu_reg2};
    q = 0;
    r = 0;
    mdu_busy = is_long_op(mdu_op) && (stuck || ucyc < 35);
    case (mdu_op)
      OP_MUL, OP_MULT: mdu_ret = 64'(sp);
      OP_MULTU:        mdu_ret = up;
      OP_MADD:         mdu_ret = mdu_hilo + 64'(sp);
      OP_MADDU:        mdu_ret = mdu_hilo + up;
      OP_MSUB:         mdu_ret = mdu_hilo - 64'(sp);
      OP_MSUBU:        mdu_ret = mdu_hilo - up;
      OP_DIV: begin
        if (mdu_reg2 != 0) begin
          q = $signed(mdu_reg1) / $signed(mdu_reg2);
          r = $signed(mdu_reg1) % $signed(mdu_reg2);
        end
        mdu_ret = {32'(r), 32'(q)};
      end
      OP_DIVU: begin
        if (mdu_reg2 != 0) mdu_ret = {mdu_reg1 % mdu_reg2, mdu_reg1 / mdu_reg2};
        else               mdu_ret = 64'd0;
      end
      default: mdu_ret = 64'd0;
    endcase
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a result.
  always @(negedge clk) begin
    if (obs) begin
      if (hilo_q.size() == 0) check("hilo_q_empty", 64'd1, 64'd0);
      else check("hilo", hilo, hilo_q.pop_front());
    end
    if (mul_valid) begin
      if (mul_q.size() == 0) check("unexpected_mul_valid", 64'(mul_result), 64'hdead);
      else check("mul_result", 64'(mul_result), 64'(mul_q.pop_front()));
    end
  end

  task automatic expect_hilo(input logic [63:0] exp);
    hilo_q.push_back(exp);
    obs = 1'b1;
    @(negedge clk);
    #1 obs = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Presents one instruction from just after a posedge until EX would advance.
  task automatic run_op(input Oper_t op, input logic [31:0] a, input logic [31:0] b,
                        input int flush_at, output int nstall);
    int cyc;
    bit done;
    nstall = 0;
    cyc = 0;
    done = 0;
    req_valid = 1'b1;
    req_op = op;
    req_reg1 = a;
    req_reg2 = b;
    while (!done && cyc < 100) begin
      flush = (cyc == flush_at);
      @(negedge clk);
      if (flush) begin
        check("flush_stall_low", 64'(stall_req), 64'd0);
        check("mdu_flush", 64'(mdu_flush), 64'd1);
        done = 1;
      end else if (stall_req) begin
        nstall++;
      end else begin
        check("mdu_op", 64'(mdu_op), is_long_op(op) ? 64'(OP_NOP) : 64'(op));
        done = 1;
      end
      @(posedge clk);
      #1 cyc++;
    end
    if (!done) check("op_completion_bound", 64'd0, 64'd1);
    flush = 1'b0;
    req_valid = 1'b0;
    req_op = OP_NOP;
  endtask

  initial begin
    int n;
    #1 rst = 1'b1;
    #6;
    check("rst_hilo", hilo, 64'd0);
    check("rst_stall", 64'(stall_req), 64'd0);
    check("rst_mul_valid", 64'(mul_valid), 64'd0);
    check("rst_timeout", 64'(timeout), 64'd0);
    check("rst_mdu_op", 64'(mdu_op), 64'(OP_NOP));
    #6 rst = 1'b0;
    @(posedge clk);
    #1;

    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'd2, -1, n);
    check("multu_stall", 64'(n), 64'd0);
    expect_hilo(64'h0000_0001_FFFF_FFFE);

    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, -1, n);
    check("div_stall", 64'(n), 64'd36);
    expect_hilo(64'hFFFF_FFFF_FFFF_FFFD);

    run_op(OP_MTLO, 32'h0000_1234, 32'd0, -1, n);
    expect_hilo(64'hFFFF_FFFF_0000_1234);
    mul_q.push_back(32'hFFFF_FFF1);
    run_op(OP_MUL, 32'hFFFF_FFFD, 32'd5, -1, n);
    check("mul_stall", 64'(n), 64'd36);
    expect_hilo(64'hFFFF_FFFF_0000_1234);

    run_op(OP_MTHI, 32'd0, 32'd0, -1, n);
    run_op(OP_MTLO, 32'hFFFF_FFFF, 32'd0, -1, n);
    run_op(OP_MADD, 32'd1, 32'd1, -1, n);
    expect_hilo(64'h0000_0001_0000_0000);

    run_op(OP_MTLO, 32'h77, 32'd0, 0, n);
    expect_hilo(64'h0000_0001_0000_0000);

    run_op(OP_DIVU, 32'd100, 32'd7, 10, n);
    check("divu_flush_stall", 64'(n), 64'd10);
    expect_hilo(64'h0000_0001_0000_0000);
    run_op(OP_MTHI, 32'hA5, 32'd0, -1, n);
    expect_hilo(64'h0000_00A5_0000_0000);

    run_op(OP_MUL, 32'd2, 32'd3, 36, n);
    check("mul_done_flush_stall", 64'(n), 64'd36);
    run_op(OP_MULTU, 32'd3, 32'd4, -1, n);
    run_op(OP_MSUBU, 32'd1, 32'd2, -1, n);
    expect_hilo(64'h0000_0000_0000_000A);

    stuck = 1'b1;
    run_op(OP_DIV, 32'd9, 32'd3, -1, n);
    stuck = 1'b0;
    check("timeout_stall", 64'(n), 64'd41);
    check("timeout_set", 64'(timeout), 64'd1);
    expect_hilo(64'h0000_0000_0000_000A);
    check("timeout_sticky", 64'(timeout), 64'd1);

    #2 rst = 1'b1;
    #1;
    check("async_rst_timeout", 64'(timeout), 64'd0);
    check("async_rst_hilo", hilo, 64'd0);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;

    check("mul_q_drained", 64'(mul_q.size()), 64'd0);
    check("hilo_q_drained", 64'(hilo_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
